// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared constants and state encoding for the IF fetch controller
package if_fetch_ctrl_pkg;

  localparam logic [31:0] IF_INIT_ADDR    = 32'h0000_3000;
  localparam logic [31:0] IF_HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] IF_IM_BEGIN     = 32'h0000_3000;
  localparam logic [31:0] IF_IM_END       = 32'h0000_4FFF;
  localparam int          IF_ADDR_W       = 11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/if_fetch_ctrl_im_addr_check.sv
// rtl/if_fetch_ctrl_im_addr_check.sv - alignment/range check and BRAM word index of a byte address
module if_fetch_ctrl_im_addr_check
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] LO_ADDR = IF_IM_BEGIN,
  parameter logic [31:0] HI_ADDR = IF_IM_END,
  parameter int          ADDR_W  = IF_ADDR_W
) (
  input  logic [31:0]       addr,
  output logic              legal,
  output logic [ADDR_W-1:0] index
);

  logic aligned;
  logic in_range;

  assign aligned  = (addr[1:0] == 2'b00);
  assign in_range = (addr >= LO_ADDR) && (addr <= HI_ADDR);
  assign legal    = aligned && in_range;
  // Illegal addresses map to word 0 so the BRAM port never sees a stray index
  assign index    = legal ? (addr[ADDR_W+1:2] - LO_ADDR[ADDR_W+1:2]) : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF stage PC/BRAM sequencer with boot-time loader arbitration
// Optional Fetch_Count output enabled by defining FETCH_COUNT_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] INIT_ADDR    = IF_INIT_ADDR,
  parameter logic [31:0] HANDLER_ADDR = IF_HANDLER_ADDR,
  parameter logic [31:0] IM_BEGIN     = IF_IM_BEGIN,
  parameter logic [31:0] IM_END       = IF_IM_END,
  parameter int          ADDR_W       = IF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Branch_Jump,
  input  logic [31:0]       PC_Update,
  input  logic              Handler,
  input  logic              Load_Mode,
  input  logic              Load_Req,
  input  logic [31:0]       Load_Addr,
  input  logic [31:0]       Load_Data,
  output logic              Load_Ack,
  output logic [ADDR_W-1:0] Im_Addr,
  output logic              Im_En,
  output logic              Im_We,
  output logic [31:0]       Im_Din,
  input  logic [31:0]       Im_Dout,
  output logic [31:0]       PC,
  output logic [31:0]       PC4,
  output logic [31:0]       Instr,
  output logic              Valid,
  output logic              IF_Error
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       Fetch_Count
`endif
);

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic              valid, valid_nxt;
  logic              pc_err;
  logic              load_ack;
  logic              fetch;
  logic              nxt_legal, load_legal;
  logic [ADDR_W-1:0] nxt_index, load_index;

  if_fetch_ctrl_im_addr_check #(.LO_ADDR(IM_BEGIN), .HI_ADDR(IM_END), .ADDR_W(ADDR_W)) u_chk_fetch (
    .addr  (pc_nxt),
    .legal (nxt_legal),
    .index (nxt_index)
  );

  if_fetch_ctrl_im_addr_check #(.LO_ADDR(IM_BEGIN), .HI_ADDR(IM_END), .ADDR_W(ADDR_W)) u_chk_load (
    .addr  (Load_Addr),
    .legal (load_legal),
    .index (load_index)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_BOOT;
      pc       <= INIT_ADDR;
      valid    <= 1'b0;
      pc_err   <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      valid    <= valid_nxt;
      pc_err   <= ~nxt_legal;
      load_ack <= (state == ST_LOAD) && Load_Req;
    end
  end

  // Next-PC selection; fetch marks a cycle where the PC moves and BRAM must read
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = valid;
    fetch     = 1'b0;
    case (state)
      ST_BOOT: begin
        pc_nxt = INIT_ADDR;
        fetch  = 1'b1;
        if (Load_Mode) begin
          state_nxt = ST_LOAD;
          valid_nxt = 1'b0;
        end else begin
          state_nxt = ST_RUN;
          valid_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (Load_Mode) begin
          state_nxt = ST_LOAD;
          valid_nxt = 1'b0;
        end else if (Handler) begin
          pc_nxt = HANDLER_ADDR;
          fetch  = 1'b1;
        end else if (Enable) begin
          pc_nxt = Branch_Jump ? PC_Update : pc + 32'd4;
          fetch  = 1'b1;
        end
      end
      ST_LOAD: begin
        valid_nxt = 1'b0;
        if (!Load_Mode) begin
          state_nxt = ST_BOOT;
          pc_nxt    = INIT_ADDR;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
        pc_nxt    = INIT_ADDR;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    Im_En   = 1'b0;
    Im_We   = 1'b0;
    Im_Addr = '0;
    if (state == ST_LOAD) begin
      if (Load_Req && load_legal) begin
        Im_En   = 1'b1;
        Im_We   = 1'b1;
        Im_Addr = load_index;
      end
    end else if (fetch && nxt_legal) begin
      Im_En   = 1'b1;
      Im_Addr = nxt_index;
    end
  end

  assign Im_Din   = Load_Data;
  assign Load_Ack = load_ack;
  assign PC       = pc;
  assign PC4      = pc + 32'd4;
  assign Valid    = valid;
  assign IF_Error = pc_err;
  assign Instr    = (valid && !pc_err) ? Im_Dout : 32'd0;

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fetch_count <= 32'd0;
    end else if (state_nxt == ST_LOAD && state != ST_LOAD) begin
      fetch_count <= 32'd0;
    end else if (state == ST_RUN && Im_En) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign Fetch_Count = fetch_count;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed vector bench for if_fetch_ctrl with a BRAM model
module tb_if_fetch_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        Branch_Jump = 1'b0;
  logic [31:0] PC_Update = 32'd0;
  logic        Handler = 1'b0;
  logic        Load_Mode = 1'b0;
  logic        Load_Req = 1'b0;
  logic [31:0] Load_Addr = 32'd0;
  logic [31:0] Load_Data = 32'd0;
  logic        Load_Ack;
  logic [10:0] Im_Addr;
  logic        Im_En;
  logic        Im_We;
  logic [31:0] Im_Din;
  logic [31:0] Im_Dout;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] Instr;
  logic        Valid;
  logic        IF_Error;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [2048];
  bit          written [2048];

  if_fetch_ctrl dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .Branch_Jump (Branch_Jump),
    .PC_Update   (PC_Update),
    .Handler     (Handler),
    .Load_Mode   (Load_Mode),
    .Load_Req    (Load_Req),
    .Load_Addr   (Load_Addr),
    .Load_Data   (Load_Data),
    .Load_Ack    (Load_Ack),
    .Im_Addr     (Im_Addr),
    .Im_En       (Im_En),
    .Im_We       (Im_We),
    .Im_Din      (Im_Din),
    .Im_Dout     (Im_Dout),
    .PC          (PC),
    .PC4         (PC4),
    .Instr       (Instr),
    .Valid       (Valid),
    .IF_Error    (IF_Error)
  );

  always #5 Clock = ~Clock;

  // Read-first BRAM; unwritten words read back as C0DE_0000 | word index
  always @(posedge Clock) begin
    if (Im_En) begin
      if (Im_We) begin
        mem[Im_Addr]     <= Im_Din;
        written[Im_Addr] <= 1'b1;
      end
      Im_Dout <= written[Im_Addr] ? mem[Im_Addr] : {16'hC0DE, 5'd0, Im_Addr};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        bj;
    logic        hd;
    logic [31:0] upd;
    logic        exp_im_en;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t v [17];
    v[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3000, 32'hC0DE0000, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3004, 32'hC0DE0001, 1'b0};
    v[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3008, 32'hC0DE0002, 1'b0};
    v[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3008, 32'hC0DE0002, 1'b0};
    v[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3008, 32'hC0DE0002, 1'b0};
    v[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h300C, 32'hC0DE0003, 1'b0};
    v[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3010, 32'hC0DE0004, 1'b0};
    v[7]  = '{1'b1, 1'b1, 1'b0, 32'h3100, 1'b1, 32'h3100, 32'hC0DE0040, 1'b0};
    v[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3104, 32'hC0DE0041, 1'b0};
    v[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,    1'b1, 32'h4180, 32'hC0DE0460, 1'b0};
    v[10] = '{1'b1, 1'b1, 1'b0, 32'h3002, 1'b0, 32'h3002, 32'h00000000, 1'b1};
    v[11] = '{1'b1, 1'b1, 1'b0, 32'h5000, 1'b0, 32'h5000, 32'h00000000, 1'b1};
    v[12] = '{1'b1, 1'b1, 1'b0, 32'h4FFC, 1'b1, 32'h4FFC, 32'hC0DE07FF, 1'b0};
    v[13] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h5000, 32'h00000000, 1'b1};
    v[14] = '{1'b1, 1'b1, 1'b0, 32'h3020, 1'b1, 32'h3020, 32'hC0DE0008, 1'b0};
    v[15] = '{1'b1, 1'b1, 1'b0, 32'h2FFC, 1'b0, 32'h2FFC, 32'h00000000, 1'b1};
    v[16] = '{1'b1, 1'b1, 1'b0, 32'h3000, 1'b1, 32'h3000, 32'hC0DE0000, 1'b0};

    repeat (2) @(negedge Clock);
    chk("reset_pc", PC, 32'h3000);
    chk("reset_valid", {31'd0, Valid}, 32'd0);
    chk("reset_ack", {31'd0, Load_Ack}, 32'd0);
    chk("reset_we", {31'd0, Im_We}, 32'd0);

    Reset  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      Enable      = v[i].en;
      Branch_Jump = v[i].bj;
      Handler     = v[i].hd;
      PC_Update   = v[i].upd;
      #1;
      chk($sformatf("v%0d_im_en", i), {31'd0, Im_En}, {31'd0, v[i].exp_im_en});
      @(negedge Clock);
      chk($sformatf("v%0d_pc", i), PC, v[i].exp_pc);
      chk($sformatf("v%0d_pc4", i), PC4, v[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_instr", i), Instr, v[i].exp_instr);
      chk($sformatf("v%0d_valid", i), {31'd0, Valid}, 32'd1);
      chk($sformatf("v%0d_err", i), {31'd0, IF_Error}, {31'd0, v[i].exp_err});
    end

    Enable = 1'b0; Branch_Jump = 1'b0; Handler = 1'b0;
    Load_Req = 1'b1; Load_Addr = 32'h3000; Load_Data = 32'h11111111;
    #1 chk("run_req_we", {31'd0, Im_We}, 32'd0);
    @(negedge Clock);
    chk("run_req_ack", {31'd0, Load_Ack}, 32'd0);

    Load_Req = 1'b0; Load_Mode = 1'b1;
    #1 chk("load_entry_im_en", {31'd0, Im_En}, 32'd0);
    @(negedge Clock);
    chk("load_valid", {31'd0, Valid}, 32'd0);
    chk("load_instr", Instr, 32'd0);

    Load_Req = 1'b1; Load_Addr = 32'h3000; Load_Data = 32'hDEADBEEF;
    #1;
    chk("load1_we", {31'd0, Im_We}, 32'd1);
    chk("load1_en", {31'd0, Im_En}, 32'd1);
    chk("load1_addr", {21'd0, Im_Addr}, 32'd0);
    chk("load1_din", Im_Din, 32'hDEADBEEF);
    @(negedge Clock);
    chk("load1_ack", {31'd0, Load_Ack}, 32'd1);

    Load_Addr = 32'h6000; Load_Data = 32'h12345678;
    #1;
    chk("load2_we", {31'd0, Im_We}, 32'd0);
    chk("load2_en", {31'd0, Im_En}, 32'd0);
    @(negedge Clock);
    chk("load2_ack", {31'd0, Load_Ack}, 32'd1);

    Load_Req = 1'b0;
    @(negedge Clock);
    chk("load_idle_ack", {31'd0, Load_Ack}, 32'd0);

    Load_Mode = 1'b0; Enable = 1'b1;
    @(negedge Clock);
    chk("boot_valid", {31'd0, Valid}, 32'd0);
    chk("boot_pc", PC, 32'h3000);
    chk("boot_im_en", {31'd0, Im_En}, 32'd1);
    @(negedge Clock);
    chk("post_load_pc", PC, 32'h3000);
    chk("post_load_instr", Instr, 32'hDEADBEEF);
    chk("post_load_valid", {31'd0, Valid}, 32'd1);

    // Write issued in the same cycle Load_Mode drops must still land and ack
    Enable = 1'b0; Load_Mode = 1'b1;
    @(negedge Clock);
    Load_Req = 1'b1; Load_Addr = 32'h3004; Load_Data = 32'hCAFEF00D; Load_Mode = 1'b0;
    #1 chk("exit_we", {31'd0, Im_We}, 32'd1);
    @(negedge Clock);
    chk("exit_ack", {31'd0, Load_Ack}, 32'd1);
    Load_Req = 1'b0; Enable = 1'b1;
    @(negedge Clock);
    chk("exit_pc0", PC, 32'h3000);
    chk("exit_instr0", Instr, 32'hDEADBEEF);
    @(negedge Clock);
    chk("exit_pc1", PC, 32'h3004);
    chk("exit_instr1", Instr, 32'hCAFEF00D);

    Enable = 1'b0; Load_Mode = 1'b1;
    @(negedge Clock);
    Load_Req = 1'b1; Load_Addr = 32'h3008; Load_Data = 32'h0;
    @(negedge Clock);
    #1;
    chk("pre_rst_we", {31'd0, Im_We}, 32'd1);
    chk("pre_rst_ack", {31'd0, Load_Ack}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    chk("rst_we", {31'd0, Im_We}, 32'd0);
    chk("rst_ack", {31'd0, Load_Ack}, 32'd0);
    chk("rst_pc", PC, 32'h3000);
    chk("rst_valid", {31'd0, Valid}, 32'd0);
    Load_Req = 1'b0; Load_Mode = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rst_recover_valid", {31'd0, Valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Sequences the synchronous instruction-memory BRAM (1-cycle read latency, single port, word-addressed) for the IF stage: owns PC, drives BRAM address/enable, and aligns returned data with its PC. Also arbitrates the same BRAM port between fetch and the boot-time program loader, which writes code while the CPU is frozen. Sits between the IF/ID pipeline register, the PC-update logic (branch/jump, exception handler) and the IM BRAM.

Parameters:
INIT_ADDR, 32'h00003000, PC after reset and after leaving load mode
HANDLER_ADDR, 32'h00004180, exception handler entry
IM_BEGIN, 32'h00003000, lowest legal fetch/load address
IM_END, 32'h00004FFF, highest legal fetch/load address
ADDR_W, 11, BRAM word-address width, (IM_END-IM_BEGIN+1)/4 = 2^ADDR_W

Ports:
Clock  in  1  sole clock, rising edge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  pipeline advance (0 = IF stall)
Branch_Jump  in  1  take PC_Update on advance
PC_Update  in  32  branch/jump target
Handler  in  1  redirect to HANDLER_ADDR, overrides Enable
Load_Mode  in  1  level: loader owns BRAM, CPU frozen
Load_Req  in  1  loader write strobe
Load_Addr  in  32  loader byte address
Load_Data  in  32  loader write data
Load_Ack  out  1  registered ack, one per Load_Req
Im_Addr  out  ADDR_W  BRAM address
Im_En  out  1  BRAM enable
Im_We  out  1  BRAM write enable
Im_Din  out  32  BRAM write data (= Load_Data)
Im_Dout  in  32  BRAM read data, valid 1 cycle after address
PC  out  32  address of instruction on Instr
PC4  out  32  PC+4
Instr  out  32  fetched instruction
Valid  out  1  Instr/PC meaningful
IF_Error  out  1  PC misaligned or outside [IM_BEGIN, IM_END]

Behaviour:
- States: BOOT, RUN, LOAD. Reset (async, low) -> BOOT; PC=INIT_ADDR, Valid=0, Load_Ack=0, Im_We=0.
- BOOT (one cycle): Im_En=1, Im_Addr=index(INIT_ADDR), Valid=0; -> LOAD if Load_Mode else RUN with PC=INIT_ADDR, Valid=1.
- RUN next-PC priority: Load_Mode (-> LOAD, Valid=0) > Handler (HANDLER_ADDR) > Enable&Branch_Jump (PC_Update) > Enable (PC+4) > hold.
- Im_Addr = (next_pc-IM_BEGIN)[ADDR_W+1:2], combinational from next-PC mux; Im_En=1 on any PC change, 0 on hold, so BRAM output and PC stay aligned with zero bubbles, including on redirect (delay slot preserved).
- Stall: Enable=0, Handler=0 -> PC, Instr, Valid unchanged, Im_En=0.
- Illegal next_pc (bits[1:0]!=0 or out of range): Im_En=0, Im_Addr=0; PC still takes the value; IF_Error=1 and Instr=0 while PC illegal.
- Instr = (Valid & ~IF_Error) ? Im_Dout : 0.
- LOAD: Valid=0, Instr=0, fetch frozen. Load_Req: Im_En=1, Im_We=1 only if Load_Addr aligned and in range, else write dropped; Load_Ack=1 next cycle regardless. Load_Mode falls -> BOOT (restart at INIT_ADDR); any Load_Req that same cycle still completes/acked.
- Load_Req outside LOAD ignored, no ack. PC4 = PC+4, 32-bit wrap.

Optional Feature:
FETCH_COUNT_EN: defined -> extra output Fetch_Count[31:0], counts cycles where RUN and Im_En=1 with legal address, cleared by Reset and on LOAD entry, wraps at 2^32. Undefined -> port absent, no counter logic.

Decomposition:
Shared package: INIT/HANDLER/IM_BEGIN/IM_END constants, ADDR_W, state encoding (BOOT/RUN/LOAD). One natural sub-module: im_addr_check (combinational: aligned, in-range, word index), used for both fetch and load paths.

Test Plan:
- Release Reset, Enable=1 -> Valid=0 one cycle, then PC=0x3000, 0x3004, 0x3008 with Instr=mem[0],[1],[2].
- Enable=0 two cycles at PC=0x3008 -> PC/Instr held, Im_En=0; Enable=1 -> PC=0x300C.
- Branch_Jump=1, PC_Update=0x3100 at PC=0x3010 -> next PC=0x3100, Instr=mem[0x40], no bubble; Handler=1 with Enable=0 -> PC=0x4180, Instr=mem[1120].
- PC_Update=0x3002 and 0x5000 -> IF_Error=1, Instr=0, Im_En=0 for that fetch.
- Load_Mode=1, writes 0xDEADBEEF@0x3000 and 0x12345678@0x6000 -> two Load_Ack pulses, only first Im_We; drop Load_Mode -> BOOT, then PC=0x3000, Instr=0xDEADBEEF.
- Assert Reset mid-LOAD with Load_Req=1 -> immediate Im_We=0, Load_Ack=0, PC=0x3000, Valid=0.
